// File: rtl/peg_l2_params.sv
// Shared state encoding and constants for the PEG L2 TX packet arbiter.
package peg_l2_params;

    typedef enum logic {
        IDLE_S = 1'b0,
        LOCK_S = 1'b1
    } arb_state_e;

    localparam int unsigned DROP_CNT_W = 16;
    localparam int unsigned GNT_ID_W   = 2;

endpackage

// File: rtl/peg_l2_rr_sel.sv
// Combinational round-robin selector: first requester strictly after ptr wins.
module peg_l2_rr_sel #(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt_oh,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
    output logic                       gnt_any
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = IDX_W'((32'(ptr) + off) % NUM_REQ);
            if (!gnt_any && req[cand]) begin
                gnt_any      = 1'b1;
                gnt_oh[cand] = 1'b1;
                gnt_idx      = cand;
            end
        end
    end

endmodule

// File: rtl/peg_l2_tx_pkt_arb.sv
// Packet-locked arbiter feeding the RMII TX block from NUM_REQ requesters.
// Define PEG_L2_TX_ARB_STRICT_PRIO_EN for fixed priority (lowest index wins).
module peg_l2_tx_pkt_arb
    import peg_l2_params::*;
#(
    parameter int unsigned PKT_DATA_W = 8,
    parameter int unsigned PKT_SIZE_W = 16,
    parameter int unsigned NUM_REQ    = 2
) (
    input  logic                          rmii_ref_clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_pkt_valid,
    input  logic [NUM_REQ-1:0]            req_pkt_sop,
    input  logic [NUM_REQ-1:0]            req_pkt_eop,
    input  logic [NUM_REQ-1:0]            req_pkt_error,
    input  logic [NUM_REQ*PKT_DATA_W-1:0] req_pkt_data,
    input  logic [NUM_REQ*PKT_SIZE_W-1:0] req_pkt_size,
    output logic [NUM_REQ-1:0]            req_pkt_ready,
    output logic                          pkt_valid,
    output logic                          pkt_sop,
    output logic                          pkt_eop,
    output logic                          pkt_error,
    output logic [PKT_DATA_W-1:0]         pkt_data,
    output logic [PKT_SIZE_W-1:0]         pkt_size,
    input  logic                          pkt_ready,
    output logic [GNT_ID_W-1:0]           arb_gnt_id,
    output logic                          arb_busy,
    output logic [DROP_CNT_W-1:0]         arb_drop_cnt
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    arb_state_e            state_q;
    logic [IDX_W-1:0]      gnt_q;
    logic [NUM_REQ-1:0]    gnt_oh_q;
    logic [DROP_CNT_W-1:0] drop_q;
    logic [IDX_W-1:0]      ptr;
    logic [NUM_REQ-1:0]    cand;
    logic [NUM_REQ-1:0]    orphan;
    logic [NUM_REQ-1:0]    sel_oh;
    logic [IDX_W-1:0]      sel_idx;
    logic                  sel_any;
    logic [PKT_DATA_W-1:0] data_arr [NUM_REQ];
    logic [PKT_SIZE_W-1:0] size_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign data_arr[i] = req_pkt_data[i*PKT_DATA_W +: PKT_DATA_W];
        assign size_arr[i] = req_pkt_size[i*PKT_SIZE_W +: PKT_SIZE_W];
    end

    assign cand   = req_pkt_valid & req_pkt_sop;
    assign orphan = req_pkt_valid & ~req_pkt_sop;

`ifdef PEG_L2_TX_ARB_STRICT_PRIO_EN
    // A pointer pinned at the top index turns the round-robin search into fixed priority.
    assign ptr = IDX_W'(NUM_REQ - 1);
`else
    logic [IDX_W-1:0] last_q;
    assign ptr = last_q;
`endif

    peg_l2_rr_sel #(
        .NUM_REQ(NUM_REQ)
    ) u_sel (
        .req    (cand),
        .ptr    (ptr),
        .gnt_oh (sel_oh),
        .gnt_idx(sel_idx),
        .gnt_any(sel_any)
    );

    always_comb begin
        pkt_valid     = 1'b0;
        pkt_sop       = 1'b0;
        pkt_eop       = 1'b0;
        pkt_error     = 1'b0;
        pkt_data      = '0;
        pkt_size      = '0;
        req_pkt_ready = '0;
        if (state_q == LOCK_S) begin
            pkt_valid     = req_pkt_valid[gnt_q];
            pkt_sop       = req_pkt_sop[gnt_q];
            pkt_eop       = req_pkt_eop[gnt_q];
            pkt_error     = req_pkt_error[gnt_q];
            pkt_data      = data_arr[gnt_q];
            pkt_size      = size_arr[gnt_q];
            req_pkt_ready = gnt_oh_q & {NUM_REQ{pkt_ready}};
        end else if (rst_n) begin
            // Orphan beats are swallowed while idle; sop holders wait for a grant.
            req_pkt_ready = orphan;
        end
    end

    always_ff @(posedge rmii_ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE_S;
            gnt_q    <= '0;
            gnt_oh_q <= '0;
            drop_q   <= '0;
`ifndef PEG_L2_TX_ARB_STRICT_PRIO_EN
            last_q   <= IDX_W'(NUM_REQ - 1);
`endif
        end else begin
            case (state_q)
                IDLE_S: begin
                    if (sel_any) begin
                        state_q  <= LOCK_S;
                        gnt_q    <= sel_idx;
                        gnt_oh_q <= sel_oh;
                    end
                    if (|orphan && drop_q != '1) begin
                        drop_q <= drop_q + DROP_CNT_W'(1);
                    end
                end
                LOCK_S: begin
                    if (pkt_valid && pkt_ready && pkt_eop) begin
                        state_q <= IDLE_S;
`ifndef PEG_L2_TX_ARB_STRICT_PRIO_EN
                        last_q  <= gnt_q;
`endif
                    end
                end
                default: state_q <= IDLE_S;
            endcase
        end
    end

    assign arb_busy     = (state_q == LOCK_S);
    assign arb_gnt_id   = GNT_ID_W'(gnt_q);
    assign arb_drop_cnt = drop_q;

endmodule

// File: tb/tb_peg_l2_tx_pkt_arb.sv
// Scoreboard bench for peg_l2_tx_pkt_arb: directed packets, expected beats queued, monitor compares.
module tb_peg_l2_tx_pkt_arb;

    localparam int NR = 2;
    localparam int DW = 8;
    localparam int SW = 16;

    typedef struct packed {
        logic [7:0]  data;
        logic        sop;
        logic        eop;
        logic        err;
        logic [15:0] size;
        logic [1:0]  id;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NR-1:0]  rv, rs, re, rerr, rrdy;
    logic [NR*DW-1:0] rdata;
    logic [NR*SW-1:0] rsize;
    logic           pv, ps, pe, perr, prdy, busy;
    logic [DW-1:0]  pd;
    logic [SW-1:0]  psz;
    logic [1:0]     gid;
    logic [15:0]    dcnt;

    int    compared   = 0;
    int    mismatched = 0;
    beat_t exp_q[$];
    logic  chk_bubble = 1'b0;

    always #5 clk = ~clk;

    peg_l2_tx_pkt_arb #(
        .PKT_DATA_W(DW),
        .PKT_SIZE_W(SW),
        .NUM_REQ   (NR)
    ) dut (
        .rmii_ref_clk (clk),
        .rst_n        (rst_n),
        .req_pkt_valid(rv),
        .req_pkt_sop  (rs),
        .req_pkt_eop  (re),
        .req_pkt_error(rerr),
        .req_pkt_data (rdata),
        .req_pkt_size (rsize),
        .req_pkt_ready(rrdy),
        .pkt_valid    (pv),
        .pkt_sop      (ps),
        .pkt_eop      (pe),
        .pkt_error    (perr),
        .pkt_data     (pd),
        .pkt_size     (psz),
        .pkt_ready    (prdy),
        .arb_gnt_id   (gid),
        .arb_busy     (busy),
        .arb_drop_cnt (dcnt)
    );

    function automatic beat_t mk(input logic [7:0] d, input logic s, input logic e,
                                 input logic er, input logic [15:0] sz, input logic [1:0] id);
        beat_t b;
        b.data = d; b.sop = s; b.eop = e; b.err = er; b.size = sz; b.id = id;
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: timed out", name);
    endtask

    // Expected beats of one packet: data increments from base, size equals beat count.
    task automatic push_pkt(input int id, input logic [7:0] base, input int n, input int err_at);
        for (int b = 0; b < n; b++)
            exp_q.push_back(mk(base + 8'(b), b == 0, b == n - 1, b == err_at, 16'(n), 2'(id)));
    endtask

    task automatic send_pkt(input int r, input logic [7:0] base, input int n, input int err_at);
        logic acc;
        for (int b = 0; b < n; b++) begin
            rv[r] = 1'b1;
            rs[r] = (b == 0);
            re[r] = (b == n - 1);
            rerr[r] = (b == err_at);
            rdata[r*DW +: DW] = base + 8'(b);
            rsize[r*SW +: SW] = 16'(n);
            acc = 1'b0;
            for (int t = 0; t < 64 && !acc; t++) begin
                @(negedge clk);
                acc = rrdy[r];
                @(posedge clk);
                #1;
            end
            if (!acc) timeout("send_handshake");
        end
        rv[r] = 1'b0; rs[r] = 1'b0; re[r] = 1'b0; rerr[r] = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(posedge clk);
        if (exp_q.size() != 0) begin
            timeout("drain");
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares delivered beats, stable hold under backpressure, ready routing, eop bubble.
    always @(negedge clk) begin
        beat_t act;
        logic [NR-1:0] exp_rdy;
        if (!rst_n) begin
            chk_bubble = 1'b0;
        end else begin
            act = mk(pd, ps, pe, perr, psz, gid);
            if (chk_bubble) begin
                chk("bubble_valid", 32'(pv), 0);
                chk("bubble_busy", 32'(busy), 0);
                chk_bubble = 1'b0;
            end
            if (busy) begin
                exp_rdy = '0;
                exp_rdy[gid[0]] = prdy;
                chk("ready_mirror", 32'(rrdy), 32'(exp_rdy));
            end
            if (pv && prdy) begin
                if (exp_q.size() == 0) begin
                    timeout("unexpected_beat");
                end else begin
                    chk("beat", 32'(act), 32'(exp_q.pop_front()));
                    if (pe) chk_bubble = 1'b1;
                end
            end else if (pv && exp_q.size() != 0) begin
                chk("hold", 32'(act), 32'(exp_q[0]));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        rv = '0; rs = '0; re = '0; rerr = '0; rdata = '0; rsize = '0;
        prdy = 1'b1;
        rv[1] = 1'b1;
        #12;
        chk("rst_valid", 32'(pv), 0);
        chk("rst_ready", 32'(rrdy), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_gnt", 32'(gid), 0);
        chk("rst_drop", 32'(dcnt), 0);
        rv = '0;
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single requester, 4 beats, error flagged on beat 2.
        push_pkt(0, 8'hA0, 4, 2);
        fork
            send_pkt(0, 8'hA0, 4, 2);
            begin
                @(negedge clk);
                chk("sel_busy", 32'(busy), 0);
                chk("sel_valid", 32'(pv), 0);
                @(negedge clk);
                chk("lock_busy", 32'(busy), 1);
                chk("lock_gnt", 32'(gid), 0);
            end
        join
        chk("busy_after_eop", 32'(busy), 0);
        drain();

        // Contention from a fresh reset.
        reset_pulse();
`ifdef PEG_L2_TX_ARB_STRICT_PRIO_EN
        push_pkt(0, 8'h10, 2, -1);
        push_pkt(0, 8'h30, 2, -1);
        push_pkt(1, 8'h20, 2, -1);
        push_pkt(1, 8'h40, 2, -1);
`else
        push_pkt(0, 8'h10, 2, -1);
        push_pkt(1, 8'h20, 2, -1);
        push_pkt(0, 8'h30, 2, -1);
        push_pkt(1, 8'h40, 2, -1);
`endif
        fork
            begin send_pkt(0, 8'h10, 2, -1); send_pkt(0, 8'h30, 2, -1); end
            begin send_pkt(1, 8'h20, 2, -1); send_pkt(1, 8'h40, 2, -1); end
        join
        drain();

        // Backpressure: pkt_ready toggles every cycle.
        push_pkt(0, 8'hC0, 4, -1);
        fork
            send_pkt(0, 8'hC0, 4, -1);
            begin
                for (int t = 0; t < 12; t++) begin
                    @(posedge clk);
                    #1 prdy = ~prdy;
                end
                prdy = 1'b1;
            end
        join
        prdy = 1'b1;
        drain();

        // Orphan beats on req1, then on both (counter steps once per cycle).
        chk("drop_before", 32'(dcnt), 0);
        rv[1] = 1'b1; rs[1] = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            chk("orphan_ready", 32'(rrdy[1]), 1);
            @(posedge clk);
            #1;
        end
        rv = '0;
        @(negedge clk);
        chk("drop_3", 32'(dcnt), 3);
        @(posedge clk);
        #1;
        rv = 2'b11; rs = 2'b00;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rv = '0;
        @(negedge clk);
        chk("drop_both", 32'(dcnt), 5);
        @(posedge clk);
        #1;

        // Reset asserted while beat 2 is presented.
        exp_q.push_back(mk(8'h60, 1'b1, 1'b0, 1'b0, 16'd4, 2'd0));
        exp_q.push_back(mk(8'h61, 1'b0, 1'b0, 1'b0, 16'd4, 2'd0));
        rv[0] = 1'b1; rs[0] = 1'b1; re[0] = 1'b0; rdata[7:0] = 8'h60; rsize[15:0] = 16'd4;
        @(posedge clk);
        #1;
        chk("mid_lock", 32'(busy), 1);
        @(posedge clk);
        #1;
        rs[0] = 1'b0; rdata[7:0] = 8'h61;
        @(posedge clk);
        #1;
        rdata[7:0] = 8'h62;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(pv), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_ready", 32'(rrdy), 0);
        chk("midrst_drop", 32'(dcnt), 0);
        chk("midrst_queue", 32'(exp_q.size()), 0);
        exp_q.delete();
        rv = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        push_pkt(0, 8'h70, 2, -1);
        send_pkt(0, 8'h70, 2, -1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
